mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single 128-bit memory request/response port between three requesters: instruction cache refill (ID 0), data cache refill/writeback (ID 1) and the page-table walker (ID 2). Round-robin arbitration with grant lock until the request is accepted. An in-order ID FIFO tracks outstanding requests so each memory response is routed to the requester that issued it. Sits between the caches/PTW and the memory interface.

Parameters:
ADDR_W, 32, request address width
DATA_W, 128, memory line/response width
MAX_OUTST, 2, maximum outstanding requests (ID FIFO depth, power of two, >=1)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
ic_req_valid_i  in  1  icache read request
ic_req_addr_i  in  ADDR_W  icache address
ic_req_ready_o  out  1  icache request accepted
ic_rsp_valid_o  out  1  response belongs to icache
dc_req_valid_i  in  1  dcache request
dc_req_addr_i  in  ADDR_W  dcache address
dc_req_we_i  in  1  dcache write (1) / read (0)
dc_req_wdata_i  in  DATA_W  dcache write line
dc_req_ready_o  out  1  dcache request accepted
dc_rsp_valid_o  out  1  response belongs to dcache
ptw_req_valid_i  in  1  PTW read request
ptw_req_addr_i  in  ADDR_W  PTW PTE address
ptw_req_ready_o  out  1  PTW request accepted
ptw_rsp_valid_o  out  1  response belongs to PTW
rsp_data_o  out  DATA_W  response data, shared by all requesters (pass-through of mem_rsp_data_i)
mem_req_valid_o  out  1  request to memory
mem_req_addr_o  out  ADDR_W  forwarded address
mem_req_we_o  out  1  forwarded write enable (0 for ic/ptw)
mem_req_wdata_o  out  DATA_W  forwarded write data (0 for ic/ptw)
mem_req_ready_i  in  1  memory accepts request
mem_rsp_valid_i  in  1  memory response, in request order, one per request (writes included)
mem_rsp_data_i  in  DATA_W  response data
arb_busy_o  out  1  outstanding count != 0 or lock held
arb_err_o  out  1  sticky: response received with no outstanding request

Behaviour:
- Reset (async, rstn_i low): all outputs 0; rr pointer=0; lock cleared; FIFO empty; arb_err_o=0. Applies mid-transaction; in-flight responses after reset count as spurious.
- Handshake: requesters hold valid/addr/data stable until ready_o; transfer when mem_req_valid_o & mem_req_ready_i. Zero-latency combinational forwarding of the selected request.
- Grant: if lock set, grant = locked ID. Else, if FIFO not full, grant = first valid requester starting from rr pointer (order 0,1,2 wrapping). If FIFO full (count==MAX_OUTST), mem_req_valid_o=0, no grant, even if a response pops same cycle.
- Lock: mem_req_valid_o=1 & !mem_req_ready_i -> lock<=grant ID; cleared on acceptance. No grant switching while locked.
- Acceptance: only granted requester sees ready_o=mem_req_ready_i; push grant ID into FIFO; rr pointer <= (grant ID+1) mod 3.
- Response: mem_rsp_valid_i pops FIFO head; corresponding *_rsp_valid_o=1 same cycle (combinational). Requesters cannot stall responses.
- Simultaneous push and pop: both occur, count unchanged.
- Response with FIFO empty: no rsp_valid_o asserted, arb_err_o set until reset.
- Count width clog2(MAX_OUTST)+1; pointers wrap modulo MAX_OUTST.

Optional Feature:
Macro MEM_ARB_PTW_PRIO_EN. Defined: when unlocked and not full, PTW (ID 2) wins over any other valid requester; rr order applies among ic/dc only; lock still respected. Undefined: pure 3-way round-robin as above.

Decomposition:
- Package tartaruga_pkg: requester ID typedef (2-bit: REQ_IC=0, REQ_DC=1, REQ_PTW=2), NUM_MEM_REQ=3.
- Sub-module mem_arb_id_fifo: ID FIFO (push/pop/full/empty/head), depth MAX_OUTST.

Test Plan:
- ic, dc, ptw valid at cycle 0, ready=1 continuously, rr=0 -> grants ic, dc, ptw on cycles 0,1,2; responses routed 0,1,2 in order.
- ptw valid addr 0x0000_1008, ready=0 for 3 cycles, ic valid from cycle 1 -> mem_req_addr_o stays 0x0000_1008 until ready; ptw_req_ready_o only on accept cycle; ic granted next.
- MAX_OUTST=2: two accepted ic reads, no responses -> mem_req_valid_o=0 with dc valid; one response -> ic_rsp_valid_o=1, dc granted following cycle.
- dc write addr 0x8000_0040, wdata 0xA5..A5 -> mem_req_we_o=1, mem_req_wdata_o matches; ack response -> dc_rsp_valid_o=1.
- mem_rsp_valid_i with empty FIFO -> no rsp_valid_o, arb_err_o=1 until rstn_i low; rstn_i low with 1 outstanding -> arb_busy_o=0 immediately.
- With MEM_ARB_PTW_PRIO_EN, ic and ptw valid together, rr=2 -> ptw granted first.

Source files
------------

// File: rtl/tartaruga_pkg.sv
// Shared types for the memory-port arbiter: requester IDs, grant record and
// the round-robin helpers used to pick the next requester.
package tartaruga_pkg;

    localparam int NUM_MEM_REQ = 3;

    typedef enum logic [1:0] {
        REQ_IC  = 2'd0,
        REQ_DC  = 2'd1,
        REQ_PTW = 2'd2
    } mem_req_id_e;

    typedef struct packed {
        logic        valid;
        mem_req_id_e id;
    } mem_grant_t;

    // Successor in the fixed ring IC -> DC -> PTW -> IC.
    function automatic mem_req_id_e nextReqId(input mem_req_id_e id);
        case (id)
            REQ_IC:  return REQ_DC;
            REQ_DC:  return REQ_PTW;
            default: return REQ_IC;
        endcase
    endfunction

    // First asserted requester walking the ring from 'start'.
    function automatic mem_grant_t rrPick(input logic [NUM_MEM_REQ-1:0] reqs,
                                          input mem_req_id_e start);
        mem_grant_t  pick;
        mem_req_id_e cand;
        pick.valid = 1'b0;
        pick.id    = REQ_IC;
        cand       = start;
        for (int i = 0; i < NUM_MEM_REQ; i++) begin
            if (!pick.valid && reqs[cand]) begin
                pick.valid = 1'b1;
                pick.id    = cand;
            end
            cand = nextReqId(cand);
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of requester IDs for requests accepted by memory but not yet
// answered. The head names the owner of the next memory response.
module mem_arb_id_fifo
    import tartaruga_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  mem_req_id_e      i_id,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output mem_req_id_e      o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_req_id_e      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    // Pointers wrap at DEPTH; a depth of one keeps them pinned at zero.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_head   = r_mem[r_rdPtr];
    assign o_count  = r_count;

    // Storage, pointers and occupancy; push and pop together keep the count.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= REQ_IC;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_id;
                r_wrPtr        <= ptrInc(r_wrPtr);
            end
            if (w_doPop) begin
                r_rdPtr <= ptrInc(r_rdPtr);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory request/response port between icache (0), dcache (1)
// and the page-table walker (2). Round-robin grant, held while memory stalls;
// responses are routed back in request order through an ID FIFO.
// Build option: define MEM_ARB_PTW_PRIO_EN to let the PTW win every unlocked
// arbitration, with round-robin kept between icache and dcache.
module mem_port_arbiter
    import tartaruga_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int MAX_OUTST = 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              ic_req_valid_i,
    input  logic [ADDR_W-1:0] ic_req_addr_i,
    output logic              ic_req_ready_o,
    output logic              ic_rsp_valid_o,
    input  logic              dc_req_valid_i,
    input  logic [ADDR_W-1:0] dc_req_addr_i,
    input  logic              dc_req_we_i,
    input  logic [DATA_W-1:0] dc_req_wdata_i,
    output logic              dc_req_ready_o,
    output logic              dc_rsp_valid_o,
    input  logic              ptw_req_valid_i,
    input  logic [ADDR_W-1:0] ptw_req_addr_i,
    output logic              ptw_req_ready_o,
    output logic              ptw_rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              mem_req_valid_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic              mem_req_we_o,
    output logic [DATA_W-1:0] mem_req_wdata_o,
    input  logic              mem_req_ready_i,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    output logic              arb_busy_o,
    output logic              arb_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    logic [NUM_MEM_REQ-1:0] w_reqVec;
    mem_grant_t             w_pick;
    logic                   w_grantValid;
    mem_req_id_e            w_grantId;
    logic                   w_memReqValid;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_fifoFull;
    logic                   w_fifoEmpty;
    mem_req_id_e            w_headId;
    logic [CNT_W-1:0]       w_fifoCount;

    logic                   r_lockValid;
    mem_req_id_e            r_lockId;
    mem_req_id_e            r_rrPtr;
    logic                   r_err;

    assign w_reqVec = {ptw_req_valid_i, dc_req_valid_i, ic_req_valid_i};

    // Candidate winner when no grant is held.
    always_comb begin
        w_pick = '{valid: 1'b0, id: REQ_IC};
`ifdef MEM_ARB_PTW_PRIO_EN
        if (w_reqVec[REQ_PTW]) begin
            w_pick.valid = 1'b1;
            w_pick.id    = REQ_PTW;
        end else begin
            w_pick = rrPick({1'b0, w_reqVec[REQ_DC], w_reqVec[REQ_IC]}, r_rrPtr);
        end
`else
        w_pick = rrPick(w_reqVec, r_rrPtr);
`endif
    end

    // A held grant wins outright; otherwise nothing is granted once the FIFO is full.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantId    = REQ_IC;
        if (r_lockValid) begin
            w_grantValid = w_reqVec[r_lockId];
            w_grantId    = r_lockId;
        end else if (!w_fifoFull) begin
            w_grantValid = w_pick.valid;
            w_grantId    = w_pick.id;
        end
    end

    assign w_memReqValid = rstn_i & w_grantValid;
    assign w_push        = w_memReqValid & mem_req_ready_i;
    assign w_pop         = rstn_i & mem_rsp_valid_i & ~w_fifoEmpty;

    // Forward the granted request; icache and PTW never write.
    always_comb begin
        mem_req_addr_o  = '0;
        mem_req_we_o    = 1'b0;
        mem_req_wdata_o = '0;
        if (w_memReqValid) begin
            case (w_grantId)
                REQ_IC:  mem_req_addr_o = ic_req_addr_i;
                REQ_DC: begin
                    mem_req_addr_o  = dc_req_addr_i;
                    mem_req_we_o    = dc_req_we_i;
                    mem_req_wdata_o = dc_req_wdata_i;
                end
                REQ_PTW: mem_req_addr_o = ptw_req_addr_i;
                default: mem_req_addr_o = '0;
            endcase
        end
    end

    assign mem_req_valid_o = w_memReqValid;
    assign ic_req_ready_o  = w_push & (w_grantId == REQ_IC);
    assign dc_req_ready_o  = w_push & (w_grantId == REQ_DC);
    assign ptw_req_ready_o = w_push & (w_grantId == REQ_PTW);

    assign ic_rsp_valid_o  = w_pop & (w_headId == REQ_IC);
    assign dc_rsp_valid_o  = w_pop & (w_headId == REQ_DC);
    assign ptw_rsp_valid_o = w_pop & (w_headId == REQ_PTW);
    assign rsp_data_o      = rstn_i ? mem_rsp_data_i : '0;

    assign arb_busy_o = (w_fifoCount != '0) | r_lockValid;
    assign arb_err_o  = r_err;

    // Grant lock, round-robin pointer and the sticky spurious-response flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_lockValid <= 1'b0;
            r_lockId    <= REQ_IC;
            r_rrPtr     <= REQ_IC;
            r_err       <= 1'b0;
        end else begin
            if (w_push) begin
                r_lockValid <= 1'b0;
                r_rrPtr     <= nextReqId(w_grantId);
            end else if (w_memReqValid) begin
                r_lockValid <= 1'b1;
                r_lockId    <= w_grantId;
            end
            if (mem_rsp_valid_i && w_fifoEmpty) begin
                r_err <= 1'b1;
            end
        end
    end

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .CNT_W (CNT_W)
    ) u_idFifo (
        .i_clk   (clk_i),
        .i_rstn  (rstn_i),
        .i_push  (w_push),
        .i_id    (w_grantId),
        .i_pop   (w_pop),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_head  (w_headId),
        .o_count (w_fifoCount)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// traffic, checked against a queue-based reference model. Build with
// MEM_ARB_PTW_PRIO_EN defined to check the PTW-priority variant.
module tb_mem_port_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 128;
    localparam int MAX_OUTST = 2;

    logic              clk = 1'b0;
    logic              rstn_i = 1'b0;
    logic              ic_req_valid_i = 1'b0;
    logic [ADDR_W-1:0] ic_req_addr_i = '0;
    logic              ic_req_ready_o;
    logic              ic_rsp_valid_o;
    logic              dc_req_valid_i = 1'b0;
    logic [ADDR_W-1:0] dc_req_addr_i = '0;
    logic              dc_req_we_i = 1'b0;
    logic [DATA_W-1:0] dc_req_wdata_i = '0;
    logic              dc_req_ready_o;
    logic              dc_rsp_valid_o;
    logic              ptw_req_valid_i = 1'b0;
    logic [ADDR_W-1:0] ptw_req_addr_i = '0;
    logic              ptw_req_ready_o;
    logic              ptw_rsp_valid_o;
    logic [DATA_W-1:0] rsp_data_o;
    logic              mem_req_valid_o;
    logic [ADDR_W-1:0] mem_req_addr_o;
    logic              mem_req_we_o;
    logic [DATA_W-1:0] mem_req_wdata_o;
    logic              mem_req_ready_i = 1'b0;
    logic              mem_rsp_valid_i = 1'b0;
    logic [DATA_W-1:0] mem_rsp_data_i = '0;
    logic              arb_busy_o;
    logic              arb_err_o;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn_i),
        .ic_req_valid_i  (ic_req_valid_i),
        .ic_req_addr_i   (ic_req_addr_i),
        .ic_req_ready_o  (ic_req_ready_o),
        .ic_rsp_valid_o  (ic_rsp_valid_o),
        .dc_req_valid_i  (dc_req_valid_i),
        .dc_req_addr_i   (dc_req_addr_i),
        .dc_req_we_i     (dc_req_we_i),
        .dc_req_wdata_i  (dc_req_wdata_i),
        .dc_req_ready_o  (dc_req_ready_o),
        .dc_rsp_valid_o  (dc_rsp_valid_o),
        .ptw_req_valid_i (ptw_req_valid_i),
        .ptw_req_addr_i  (ptw_req_addr_i),
        .ptw_req_ready_o (ptw_req_ready_o),
        .ptw_rsp_valid_o (ptw_rsp_valid_o),
        .rsp_data_o      (rsp_data_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_we_o    (mem_req_we_o),
        .mem_req_wdata_o (mem_req_wdata_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .arb_busy_o      (arb_busy_o),
        .arb_err_o       (arb_err_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    int checks = 0;
    int errors = 0;

    // Requester intentions: a pending request is held until accepted.
    bit                reqPend [3];
    logic [ADDR_W-1:0] reqAddr [3];
    logic              reqWe = 1'b0;
    logic [DATA_W-1:0] reqWdata = '0;
    bit                memReady = 1'b0;
    bit                rspReq = 1'b0;

    // Reference model state: order of service, who is owed a response.
    int                mRr = 0;
    int                mLock = -1;
    int                mOut[$];
    bit                mErr = 1'b0;
    rsp_t              rspExpQ[$];
    logic [ADDR_W-1:0] memQ[$];
    int                lastAcc = -1;

    // Values seen on the DUT at the last sampling point.
    int                dutAccId;
    logic [2:0]        sReady;
    logic [2:0]        sRsp;
    logic              sMemValid;
    logic [ADDR_W-1:0] sAddr;
    logic              sWe;
    logic [DATA_W-1:0] sWdata;
    logic              sBusy;
    logic              sErr;

    function automatic logic [DATA_W-1:0] rspData(input logic [ADDR_W-1:0] a);
        return {a, ~a, a ^ 32'hDEAD_BEEF, a + 32'h1};
    endfunction

    // Who the arbitration rules say wins this cycle, or -1 for nobody.
    function automatic int pickGrant(input bit [2:0] v);
        int id;
        if (mLock >= 0) return v[mLock] ? mLock : -1;
        if (mOut.size() >= MAX_OUTST) return -1;
`ifdef MEM_ARB_PTW_PRIO_EN
        if (v[2]) return 2;
`endif
        for (int k = 0; k < 3; k++) begin
            id = (mRr + k) % 3;
`ifdef MEM_ARB_PTW_PRIO_EN
            if (id == 2) continue;
`endif
            if (v[id]) return id;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, check at the falling edge, advance the model.
    task automatic applyStimulus();
        bit [2:0] v;
        int       g;
        ic_req_valid_i  = reqPend[0];
        ic_req_addr_i   = reqAddr[0];
        dc_req_valid_i  = reqPend[1];
        dc_req_addr_i   = reqAddr[1];
        dc_req_we_i     = reqWe;
        dc_req_wdata_i  = reqWdata;
        ptw_req_valid_i = reqPend[2];
        ptw_req_addr_i  = reqAddr[2];
        mem_req_ready_i = memReady;
        mem_rsp_valid_i = rspReq;
        mem_rsp_data_i  = (memQ.size() > 0) ? rspData(memQ[0]) : '0;
        @(negedge clk);
        sReady    = {ptw_req_ready_o, dc_req_ready_o, ic_req_ready_o};
        sRsp      = {ptw_rsp_valid_o, dc_rsp_valid_o, ic_rsp_valid_o};
        sMemValid = mem_req_valid_o;
        sAddr     = mem_req_addr_o;
        sWe       = mem_req_we_o;
        sWdata    = mem_req_wdata_o;
        sBusy     = arb_busy_o;
        sErr      = arb_err_o;
        dutAccId  = sReady[0] ? 0 : sReady[1] ? 1 : sReady[2] ? 2 : -1;
        lastAcc   = -1;
        if (!rstn_i) begin
            mRr = 0;
            mLock = -1;
            mOut.delete();
            rspExpQ.delete();
            mErr = 1'b0;
            for (int i = 0; i < 3; i++) reqPend[i] = 1'b0;
            checkOutput("reset mem_req_valid", sMemValid, 0);
            checkOutput("reset mem_req_addr", sAddr, 0);
            checkOutput("reset ready", sReady, 0);
            checkOutput("reset rsp_valid", sRsp, 0);
            checkOutput("reset busy", sBusy, 0);
            checkOutput("reset err", sErr, 0);
        end else begin
            v = {reqPend[2], reqPend[1], reqPend[0]};
            g = pickGrant(v);
            checkOutput("mem_req_valid", sMemValid, g >= 0);
            if (g >= 0) begin
                checkOutput("mem_req_addr", sAddr, reqAddr[g]);
                checkOutput("mem_req_we", sWe, (g == 1) ? reqWe : 1'b0);
                checkOutput("mem_req_wdata", sWdata, (g == 1) ? reqWdata : '0);
            end
            checkOutput("req_ready", sReady, (g >= 0 && memReady) ? (3'b001 << g) : 3'b000);
            if (!rspReq || mOut.size() == 0) checkOutput("rsp idle", sRsp, 0);
            checkOutput("arb_busy", sBusy, (mOut.size() != 0) || (mLock >= 0));
            checkOutput("arb_err", sErr, mErr);
            if (rspReq) begin
                if (mOut.size() == 0) mErr = 1'b1;
                else void'(mOut.pop_front());
            end
            if (g >= 0) begin
                if (memReady) begin
                    mOut.push_back(g);
                    rspExpQ.push_back('{g, rspData(reqAddr[g])});
                    mRr = (g + 1) % 3;
                    mLock = -1;
                    lastAcc = g;
                end else begin
                    mLock = g;
                end
            end
        end
        if (rspReq && memQ.size() > 0) void'(memQ.pop_front());
        if (sMemValid && mem_req_ready_i) memQ.push_back(sAddr);
        @(posedge clk);
        #1;
        if (lastAcc >= 0) reqPend[lastAcc] = 1'b0;
        rspReq = 1'b0;
    endtask

    // Let memory answer everything and requesters finish, within a bound.
    task automatic drainAll();
        int left;
        memReady = 1'b1;
        for (int c = 0; c < 100; c++) begin
            left = memQ.size() + reqPend[0] + reqPend[1] + reqPend[2];
            if (left == 0) break;
            rspReq = (memQ.size() > 0);
            applyStimulus();
        end
        checkOutput("drain", memQ.size() + reqPend[0] + reqPend[1] + reqPend[2], 0);
    endtask

    // Response monitor: whenever the DUT routes a response, compare with the scoreboard.
    initial begin
        rsp_t       e;
        logic [2:0] vec;
        forever begin
            @(negedge clk);
            vec = {ptw_rsp_valid_o, dc_rsp_valid_o, ic_rsp_valid_o};
            if (rstn_i === 1'b1 && vec != 3'b000) begin
                if (rspExpQ.size() == 0) begin
                    checkOutput("rsp unexpected", vec, 0);
                end else begin
                    e = rspExpQ.pop_front();
                    checkOutput("rsp route", vec, 3'b001 << e.id);
                    checkOutput("rsp data", rsp_data_o, e.data);
                end
            end
        end
    end

    // Hard stop if something stalls forever.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        logic [31:0] r;
        for (int i = 0; i < 3; i++) begin
            reqPend[i] = 1'b0;
            reqAddr[i] = '0;
        end
        @(posedge clk);
        #1;
        applyStimulus();
        rstn_i = 1'b1;
        applyStimulus();

        $display("[TB] all three request together from a fresh pointer");
        reqPend[0] = 1; reqAddr[0] = 32'h1000_0000;
        reqPend[1] = 1; reqAddr[1] = 32'h2000_0100;
        reqPend[2] = 1; reqAddr[2] = 32'h3000_0200;
        memReady = 1;
        applyStimulus();
        checkOutput("t1 grant cycle0", dutAccId, 0);
        rspReq = 1;
        applyStimulus();
        checkOutput("t1 grant cycle1", dutAccId, 1);
        rspReq = 1;
        applyStimulus();
        checkOutput("t1 grant cycle2", dutAccId, 2);
        drainAll();

        $display("[TB] stalled PTW keeps the grant");
        memReady = 0;
        reqPend[2] = 1; reqAddr[2] = 32'h0000_1008;
        applyStimulus();
        checkOutput("t2 held addr c0", sAddr, 32'h0000_1008);
        reqPend[0] = 1; reqAddr[0] = 32'h1000_0040;
        for (int c = 1; c < 3; c++) begin
            applyStimulus();
            checkOutput("t2 held addr", sAddr, 32'h0000_1008);
            checkOutput("t2 no ready", sReady, 3'b000);
        end
        memReady = 1;
        applyStimulus();
        checkOutput("t2 accept ptw", sReady, 3'b100);
        applyStimulus();
        checkOutput("t2 then ic", sReady, 3'b001);
        drainAll();

        $display("[TB] full FIFO blocks new grants");
        reqPend[0] = 1; reqAddr[0] = 32'h1000_0080;
        applyStimulus();
        reqPend[0] = 1; reqAddr[0] = 32'h1000_00C0;
        applyStimulus();
        reqPend[1] = 1; reqAddr[1] = 32'h2000_0000;
        applyStimulus();
        checkOutput("t3 full no valid", sMemValid, 0);
        rspReq = 1;
        applyStimulus();
        checkOutput("t3 ic rsp", sRsp, 3'b001);
        checkOutput("t3 full same cycle", sMemValid, 0);
        applyStimulus();
        checkOutput("t3 dc granted", sReady, 3'b010);
        drainAll();

        $display("[TB] dcache write forwarding");
        reqPend[1] = 1; reqAddr[1] = 32'h8000_0040;
        reqWe = 1; reqWdata = {16{8'hA5}};
        applyStimulus();
        checkOutput("t4 we", sWe, 1);
        checkOutput("t4 wdata", sWdata, {16{8'hA5}});
        checkOutput("t4 ready", sReady, 3'b010);
        reqWe = 0; reqWdata = '0;
        rspReq = 1;
        applyStimulus();
        checkOutput("t4 dc rsp", sRsp, 3'b010);
        drainAll();

        $display("[TB] spurious response and mid-flight reset");
        rspReq = 1;
        applyStimulus();
        checkOutput("t5 no route", sRsp, 3'b000);
        applyStimulus();
        checkOutput("t5 err set", sErr, 1);
        reqPend[0] = 1; reqAddr[0] = 32'h1000_0100;
        applyStimulus();
        applyStimulus();
        checkOutput("t5 busy outstanding", sBusy, 1);
        rstn_i = 0;
        applyStimulus();
        checkOutput("t5 busy in reset", sBusy, 0);
        checkOutput("t5 err in reset", sErr, 0);
        rstn_i = 1;
        applyStimulus();
        rspReq = 1;
        applyStimulus();
        checkOutput("t5 late rsp unrouted", sRsp, 3'b000);
        applyStimulus();
        checkOutput("t5 late rsp err", sErr, 1);
        rstn_i = 0;
        applyStimulus();
        rstn_i = 1;
        applyStimulus();

        $display("[TB] PTW and icache together with pointer at PTW");
        reqPend[1] = 1; reqAddr[1] = 32'h2000_0200;
        applyStimulus();
        drainAll();
        reqPend[0] = 1; reqAddr[0] = 32'h1000_0200;
        reqPend[2] = 1; reqAddr[2] = 32'h3000_0300;
        applyStimulus();
        checkOutput("t6 ptw first", sReady, 3'b100);
        applyStimulus();
        checkOutput("t6 ic second", sReady, 3'b001);
        drainAll();

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!reqPend[i] && $urandom_range(0, 2) == 0) begin
                    r = $urandom();
                    reqPend[i] = 1;
                    reqAddr[i] = {4'(i + 1), r[27:4], 4'h0};
                    if (i == 1) begin
                        reqWe    = r[0];
                        reqWdata = {$urandom(), $urandom(), $urandom(), $urandom()};
                    end
                end
            end
            memReady = ($urandom_range(0, 3) != 0);
            rspReq   = (memQ.size() > 0) && ($urandom_range(0, 1) == 1);
            applyStimulus();
        end
        drainAll();
        applyStimulus();
        checkOutput("scoreboard empty", rspExpQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
